// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller with a one-deep update buffer.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZ_BLANK_EN.
//
// state | meaning
// GAP   | all anodes off for one tick between digits
// SHOW  | current digit lit for DWELL_TICKS ticks
module seven_seg_scan_ctrl #(
    parameter int unsigned DWELL_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [3:0]  nibble,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS - 1);

    state_t      state_q, state_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_full_q, pend_full_d;
    logic        rdy_q;
    logic        fd_q, fd_d;
    logic        boundary;
    logic        xfer;
    logic        lit;
    logic [1:0]  msd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= GAP;
            dwell_q     <= 8'd0;
            idx_q       <= 2'd0;
            disp_q      <= 16'h0000;
            pend_q      <= 16'h0000;
            pend_full_q <= 1'b0;
            rdy_q       <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            rdy_q       <= ~pend_full_d;
            fd_q        <= fd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        idx_d    = idx_q;
        boundary = 1'b0;
        if (tick) begin
            case (state_q)
                GAP: begin
                    state_d = SHOW;
                    dwell_d = 8'd0;
                end
                SHOW: begin
                    dwell_d = dwell_q + 8'd1;
                    if (dwell_q == DWELL_LAST) begin
                        state_d  = GAP;
                        idx_d    = idx_q + 2'd1;
                        boundary = (idx_q == 2'd3);
                    end
                end
                default: state_d = GAP;
            endcase
        end
        fd_d = boundary;
    end

    // ready is registered, so a transfer can never coincide with a full buffer draining
    always_comb begin
        xfer        = upd_valid & rdy_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = upd_data;
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        msd = 2'd0;
        if (disp_q[15:12] != 4'd0)
            msd = 2'd3;
        else if (disp_q[11:8] != 4'd0)
            msd = 2'd2;
        else if (disp_q[7:4] != 4'd0)
            msd = 2'd1;
`ifdef SEVEN_SEG_LZ_BLANK_EN
        lit = (state_q == SHOW) && digit_en[idx_q] && (idx_q <= msd);
`else
        lit = (state_q == SHOW) && digit_en[idx_q];
`endif
        an = lit ? ~(4'b0001 << idx_q) : 4'b1111;
    end

    assign nibble     = disp_q[{idx_q, 2'b00} +: 4];
    assign digit_idx  = idx_q;
    assign upd_ready  = rdy_q;
    assign frame_done = fd_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL_TICKS, default 4, setting the number of tick pulses each digit stays lit (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port tick, input, 1 bit: one-clk enable pulse from clock_div; all sequencing advances only on clk edges with tick=1.
REQ-005 The block SHALL have port upd_valid, input, 1 bit: producer offers a new display value.
REQ-006 The block SHALL have port upd_data, input, 16 bits: four nibbles; digit0=[3:0], digit3=[15:12].
REQ-007 The block SHALL have port upd_ready, output, 1 bit: the pending buffer can accept a value.
REQ-008 The block SHALL have port digit_en, input, 4 bits: per-digit enable; a 0 keeps that anode off.
REQ-009 The block SHALL have port an, output, 4 bits: active-low anodes for the 7seg display.
REQ-010 The block SHALL have port nibble, output, 4 bits: value of the current digit, fed to the decoder.
REQ-011 The block SHALL have port digit_idx, output, 2 bits: index of the current digit.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-clk pulse at the end of digit 3.

Function
REQ-013 The FSM SHALL have two states: GAP (all anodes off, one tick) and SHOW (anode lit for DWELL_TICKS ticks).
REQ-014 In GAP, tick=1 SHALL move the FSM to SHOW and clear the 8-bit dwell counter.
REQ-015 In SHOW, tick=1 SHALL increment the dwell counter; tick=1 at count DWELL_TICKS-1 SHALL move to GAP and set digit_idx to (digit_idx+1) mod 4.
REQ-016 Leaving SHOW with digit_idx=3 (the frame boundary) SHALL assert frame_done for exactly that one clk.
REQ-017 A transfer SHALL occur on a clk edge with upd_valid=1 and upd_ready=1, loading upd_data into the pending buffer and setting pending_full.
REQ-018 upd_ready SHALL equal ~pending_full, a registered value with no combinational path from upd_valid.
REQ-019 At the frame boundary with pending_full=1, the display register SHALL load the pending value and pending_full SHALL clear; with pending_full=0, the display register SHALL hold.
REQ-020 A transfer on the same edge as a frame boundary with the pending buffer previously empty SHALL fill the pending buffer only; the display updates at the next boundary.
REQ-021 The display register SHALL never change mid-frame (no tearing).
REQ-022 In SHOW, an SHALL be ~(4'b0001<<digit_idx) when digit_en[digit_idx]=1, else 4'b1111; in GAP, an SHALL be 4'b1111.
REQ-023 nibble SHALL equal display[4*digit_idx +: 4] in both states.
REQ-024 an, nibble, digit_idx and upd_ready SHALL be decoded only from registered state.
REQ-025 With DWELL_TICKS=1, each digit SHALL be lit for exactly one tick, and one frame SHALL last 8 ticks.

Reset
REQ-026 reset_n=0 SHALL immediately force: FSM=GAP, digit_idx=0, dwell=0, display=16'h0000, pending_full=0, an=4'b1111, frame_done=0, nibble=0.
REQ-027 upd_ready SHALL be 0 while reset_n=0 and 1 on the first clk edge after release.
REQ-028 Reset mid-frame or with pending_full=1 SHALL discard the pending data; no transfer is acknowledged during reset.

Configuration
REQ-029 With macro SEVEN_SEG_LZ_BLANK_EN defined, digits above the most significant non-zero nibble of display SHALL keep their anode off; digit0 SHALL always follow digit_en (a display value of 0 shows a single "0").
REQ-030 Without SEVEN_SEG_LZ_BLANK_EN, anodes SHALL depend only on the FSM state, digit_idx and digit_en.

Verification
REQ-031 Scenario: reset then tick every clk, DWELL_TICKS=4, digit_en=4'hF -> an sequence 1111,1110(x4),1111,1101(x4),1111,1011(x4),1111,0111(x4); frame_done pulses after the last 0111.
REQ-032 Scenario: upd_data=16'h1234 transferred mid-frame -> nibble stays 0 until the frame boundary, then reads 4,3,2,1 for digits 0..3; upd_ready is 0 from the transfer until that boundary.
REQ-033 Scenario: second upd_valid with 16'hABCD while pending_full=1 -> no transfer; it is accepted one clk after the boundary, and the display shows 16'hABCD one frame later.
REQ-034 Scenario: digit_en=4'b0101 -> an never equals 1101 or 0111; timing is unchanged.
REQ-035 Scenario: reset_n pulsed low during SHOW of digit 2 with pending 16'h5555 -> an=1111 asynchronously, display=0, upd_ready=1 after release, 16'h5555 never displayed.
REQ-036 Scenario: SEVEN_SEG_LZ_BLANK_EN defined, display 16'h0042 -> only an=1110 and 1101 occur; display 16'h0000 -> only 1110 occurs.
